cache_mem_responder: RTL and testbench

//   Block-wide backing-memory responder for the cache miss interface (tx_* side of the cache).

---
 rtl/cache_mem_responder.sv | 105 ++++++++++
 tb/tb_cache_mem_responder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Block-wide backing store for cache refills/writebacks; optional CACHE_MEM_STATS_EN adds rd/wr counters.
// Latency: ready_o low for exactly LATENCY cycles after the accepting edge; read data valid as ready_o rises.
// Backpressure: one request in flight; re_i/we_i are ignored while ready_o=0 and re-sampled once it returns high.
module cache_mem_responder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BLOCK_SIZE = 16,
    parameter int LATENCY    = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    re_i,
    input  logic                    we_i,
    output logic                    ready_o,
    input  logic [31:0]             addr_i,
    input  logic [BLOCK_SIZE*8-1:0] wdata_i,
    output logic [BLOCK_SIZE*8-1:0] rdata_o
`ifdef CACHE_MEM_STATS_EN
    ,
    output logic [31:0]             rd_count_o,
    output logic [31:0]             wr_count_o
`endif
);
    localparam int OFF        = $clog2(BLOCK_SIZE);
    localparam int IW         = ADDR_WIDTH - OFF;
    localparam int NUM_BLOCKS = (1 << ADDR_WIDTH) / BLOCK_SIZE;
    localparam int BW         = BLOCK_SIZE * 8;
    localparam int CW         = $clog2(LATENCY + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic            wr_q;
    logic [IW-1:0]   idx_q;
    logic [BW-1:0]   wdata_q;
    logic [BW-1:0]   mem [NUM_BLOCKS];
    logic            accept, done;

    // Offset and aliased high address bits are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:ADDR_WIDTH], addr_i[OFF-1:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (re_i || we_i) begin
                accept  = 1'b1;
                state_d = BUSY;
            end
            BUSY: if (cnt_q == '0) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == IDLE);

    // A simultaneous read+write collapses to a write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            rdata_o <= '0;
        end else begin
            if (accept) begin
                cnt_q   <= CW'(LATENCY - 1);
                wr_q    <= we_i;
                idx_q   <= addr_i[ADDR_WIDTH-1:OFF];
                wdata_q <= wdata_i;
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (done && !wr_q) rdata_o <= mem[idx_q];
        end
    end

    // Storage is not reset; an abort returns to IDLE before done can fire, so no commit.
    always_ff @(posedge clk_i) begin
        if (done && wr_q) mem[idx_q] <= wdata_q;
    end

`ifdef CACHE_MEM_STATS_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_count_o <= '0;
            wr_count_o <= '0;
        end else if (done) begin
            if (wr_q) wr_count_o <= wr_count_o + 32'd1;
            else      rd_count_o <= rd_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder: LATENCY=2 instance (a) and LATENCY=4 instance (b).
module tb_cache_mem_responder;
    localparam int BW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_a, re_a, we_a, ready_a;
    logic [31:0]   addr_a;
    logic [BW-1:0] wdata_a, rdata_a;
    logic          rst_b, re_b, we_b, ready_b;
    logic [31:0]   addr_b;
    logic [BW-1:0] wdata_b, rdata_b;
`ifdef CACHE_MEM_STATS_EN
    logic [31:0]   rdc_a, wrc_a, rdc_b, wrc_b;
`endif

    int checks   = 0;
    int failures = 0;
    logic [BW-1:0] exp_a[$];
    logic [BW-1:0] exp_b[$];
    int n_rd[2];
    int n_wr[2];

    cache_mem_responder #(.ADDR_WIDTH(8), .BLOCK_SIZE(16), .LATENCY(2)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_a), .re_i(re_a), .we_i(we_a), .ready_o(ready_a),
        .addr_i(addr_a), .wdata_i(wdata_a), .rdata_o(rdata_a)
`ifdef CACHE_MEM_STATS_EN
        , .rd_count_o(rdc_a), .wr_count_o(wrc_a)
`endif
    );

    cache_mem_responder #(.ADDR_WIDTH(8), .BLOCK_SIZE(16), .LATENCY(4)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_b), .re_i(re_b), .we_i(we_b), .ready_o(ready_b),
        .addr_i(addr_b), .wdata_i(wdata_b), .rdata_o(rdata_b)
`ifdef CACHE_MEM_STATS_EN
        , .rd_count_o(rdc_b), .wr_count_o(wrc_b)
`endif
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: each rising ready_o outside reset is one completion.
    logic prev_a = 1'b1, prev_b = 1'b1;
    int   low_a = 0, low_b = 0;

    always @(negedge clk) begin
        if (!rst_a) begin
            prev_a = 1'b1;
            low_a  = 0;
        end else begin
            if (!ready_a) low_a++;
            else if (!prev_a) begin
                if (exp_a.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL a_unexpected_completion: rdata %h with empty scoreboard", rdata_a);
                end else begin
                    check("a_rdata", rdata_a, exp_a.pop_front());
                    check("a_latency", BW'(low_a), BW'(2));
                end
                low_a = 0;
            end
            prev_a = ready_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_b) begin
            prev_b = 1'b1;
            low_b  = 0;
        end else begin
            if (!ready_b) low_b++;
            else if (!prev_b) begin
                if (exp_b.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL b_unexpected_completion: rdata %h with empty scoreboard", rdata_b);
                end else begin
                    check("b_rdata", rdata_b, exp_b.pop_front());
                    check("b_latency", BW'(low_b), BW'(4));
                end
                low_b = 0;
            end
            prev_b = ready_b;
        end
    end

    task automatic set_in(input int s, input bit r, input bit w, input logic [31:0] a, input logic [BW-1:0] d);
        if (s == 0) begin re_a = r; we_a = w; addr_a = a; wdata_a = d; end
        else        begin re_b = r; we_b = w; addr_b = a; wdata_b = d; end
    endtask

    task automatic wait_ready(input int s);
        int n = 0;
        while (!(s == 1 ? ready_b : ready_a) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL timeout_ready dut%0d: ready stayed 0 for %0d cycles, required rise", s, n);
        end
    endtask

    // One request; e is the hand-computed rdata expected at completion.
    task automatic req(input int s, input bit r, input bit w, input logic [31:0] a,
                       input logic [BW-1:0] d, input logic [BW-1:0] e);
        @(negedge clk);
        set_in(s, r, w, a, d);
        if (s == 0) exp_a.push_back(e); else exp_b.push_back(e);
        if (w) n_wr[s]++; else n_rd[s]++;
        @(posedge clk); #1;
        set_in(s, 1'b0, 1'b0, 32'h0, '0);
        wait_ready(s);
    endtask

    logic [BW-1:0] d1, aa, p, q;

    initial begin
        d1 = 128'hDEADBEEF_00000000_00000000_00000001;
        aa = {16{8'hA5}};
        p  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        q  = 128'h11111111_22222222_33333333_44444444;
        n_rd = '{0, 0};
        n_wr = '{0, 0};
        rst_a = 1'b0; rst_b = 1'b0;
        set_in(0, 1'b0, 1'b0, 32'h0, '0);
        set_in(1, 1'b0, 1'b0, 32'h0, '0);
        repeat (2) @(negedge clk);
        rst_a = 1'b1; rst_b = 1'b1;
        @(negedge clk);
        check("reset_ready_a", BW'(ready_a), BW'(1));
        check("reset_rdata_a", rdata_a, '0);
        check("reset_ready_b", BW'(ready_b), BW'(1));
        check("reset_rdata_b", rdata_b, '0);

        // Write, offset-ignored read, aliased read, read+write collision, read-back.
        req(0, 1'b0, 1'b1, 32'h20,  d1, '0);
        req(0, 1'b1, 1'b0, 32'h2C,  '0, d1);
        req(0, 1'b1, 1'b0, 32'h120, '0, d1);
        req(0, 1'b1, 1'b1, 32'h40,  aa, d1);
        req(0, 1'b1, 1'b0, 32'h40,  '0, aa);

        // Back-to-back reads with re held high across completion.
        @(negedge clk);
        set_in(0, 1'b1, 1'b0, 32'h20, '0);
        exp_a.push_back(d1);
        exp_a.push_back(aa);
        n_rd[0] += 2;
        @(posedge clk); #1;
        wait_ready(0);
        addr_a = 32'h40;
        @(posedge clk); #1;
        check("b2b_second_accept", BW'(ready_a), BW'(0));
        set_in(0, 1'b0, 1'b0, 32'h0, '0);
        wait_ready(0);
`ifdef CACHE_MEM_STATS_EN
        check("a_rd_count", BW'(rdc_a), BW'(n_rd[0]));
        check("a_wr_count", BW'(wrc_a), BW'(n_wr[0]));
`endif

        // Abort a write mid-BUSY on instance a.
        @(negedge clk);
        set_in(0, 1'b0, 1'b1, 32'h20, q);
        @(posedge clk); #1;
        set_in(0, 1'b0, 1'b0, 32'h0, '0);
        check("a_abort_busy", BW'(ready_a), BW'(0));
        #2 rst_a = 1'b0;
        #1;
        check("a_abort_ready_async", BW'(ready_a), BW'(1));
        check("a_abort_rdata_cleared", rdata_a, '0);
        n_rd[0] = 0; n_wr[0] = 0;
        @(negedge clk); @(negedge clk);
        rst_a = 1'b1;
        req(0, 1'b1, 1'b0, 32'h40, '0, aa);
        req(0, 1'b1, 1'b0, 32'h20, '0, d1);
`ifdef CACHE_MEM_STATS_EN
        check("a_rd_count_after_abort", BW'(rdc_a), BW'(n_rd[0]));
        check("a_wr_count_after_abort", BW'(wrc_a), BW'(n_wr[0]));
`endif

        // LATENCY=4: reset in cycle 2 of a write leaves prior contents intact.
        req(1, 1'b0, 1'b1, 32'h50, p, '0);
        @(negedge clk);
        set_in(1, 1'b0, 1'b1, 32'h50, q);
        @(posedge clk); #1;
        set_in(1, 1'b0, 1'b0, 32'h0, '0);
        @(posedge clk); #1;
        rst_b = 1'b0;
        #1;
        check("b_abort_ready_async", BW'(ready_b), BW'(1));
        n_rd[1] = 0; n_wr[1] = 0;
        @(negedge clk); @(negedge clk);
        rst_b = 1'b1;
        req(1, 1'b1, 1'b0, 32'h50, '0, p);
`ifdef CACHE_MEM_STATS_EN
        check("b_rd_count", BW'(rdc_b), BW'(n_rd[1]));
        check("b_wr_count", BW'(wrc_b), BW'(n_wr[1]));
`endif

        repeat (3) @(negedge clk);
        check("a_scoreboard_drained", BW'(exp_a.size()), BW'(0));
        check("b_scoreboard_drained", BW'(exp_b.size()), BW'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
